// File: rtl/rf_window_streamer_if.sv
// Handshake bundle between the image loader, the window streamer and the conv units.
// The streamer sits on the slave side: it is started by, and takes pixels from, the
// environment, and offers windows back to it.
interface rf_window_streamer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int Depth      = 1,
    parameter int Size       = 5
);
    logic                                 start;
    logic                                 pixel_valid;
    logic                                 pixel_ready;
    logic [Depth*DATA_WIDTH-1:0]          pixel_data;
    logic                                 rf_valid;
    logic                                 rf_ready;
    logic [Depth*Size*Size*DATA_WIDTH-1:0] rf_data;
    logic [5:0]                           rf_row;
    logic [5:0]                           rf_col;
    logic                                 frame_done;

    modport slave (
        input  start, pixel_valid, pixel_data, rf_ready,
        output pixel_ready, rf_valid, rf_data, rf_row, rf_col, frame_done
    );

    modport master (
        output start, pixel_valid, pixel_data, rf_ready,
        input  pixel_ready, rf_valid, rf_data, rf_row, rf_col, frame_done
    );
endinterface

// File: rtl/rf_window_streamer.sv
// Streaming receptive-field generator: raster pixels in, Size x Size windows out at a
// configurable stride. Only Size-1 image lines plus one window are kept in flops.
module rf_window_streamer #(
    parameter int DATA_WIDTH = 16,
    parameter int Depth      = 1,
    parameter int Size       = 5,
    parameter int H          = 32,
    parameter int W          = 32,
    parameter int Stride     = 1
) (
    input  logic               clk,
    input  logic               reset,
    rf_window_streamer_if.slave bus
);
    localparam int PW   = Depth*DATA_WIDTH;
    localparam int RFW  = Depth*Size*Size*DATA_WIDTH;
    localparam int NPIX = H*W;
    localparam int OH   = (H-Size)/Stride + 1;
    localparam int OW   = (W-Size)/Stride + 1;
    localparam int RW   = $clog2(H);
    localparam int CW   = $clog2(W);
    localparam int NW   = $clog2(NPIX+1);
    localparam int PHW  = $clog2(Stride+1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [CW-1:0]  COL_LAST  = CW'(W-1);
    localparam logic [CW-1:0]  COL_FIRST = CW'(Size-1);
    localparam logic [RW-1:0]  ROW_FIRST = RW'(Size-1);
    localparam logic [NW-1:0]  PIX_TOTAL = NW'(NPIX);
    localparam logic [PHW-1:0] PH_LAST   = PHW'(Stride-1);
    localparam logic [5:0]     OROW_LAST = 6'(OH-1);
    localparam logic [5:0]     OCOL_LAST = 6'(OW-1);

    logic [1:0]     state;
    logic [RW-1:0]  in_row;
    logic [CW-1:0]  in_col;
    logic [NW-1:0]  in_count;
    logic [PHW-1:0] row_ph, col_ph;     // position within the stride, 0 = window anchor
    logic [5:0]     out_row, out_col;   // output-map coordinates of the next window

    logic [PW-1:0]  lb      [Size-1][W];  // lb[0] holds the oldest line
    logic [PW-1:0]  win     [Size][Size];
    logic [PW-1:0]  win_nx  [Size][Size];
    logic [PW-1:0]  col_new [Size];
    logic [RFW-1:0] rf_data_nx;

    logic           rf_valid_q;
    logic [RFW-1:0] rf_data_q;
    logic [5:0]     rf_row_q, rf_col_q;

    logic go, pixel_ready, accept, row_ok, col_ok, emit, last_hs;

    assign go          = (state == S_IDLE) && bus.start;
    assign pixel_ready = (state == S_STREAM) && (in_count < PIX_TOTAL) &&
                         (!rf_valid_q || bus.rf_ready);
    assign accept      = bus.pixel_valid && pixel_ready;
    assign row_ok      = (in_row >= ROW_FIRST) && (row_ph == '0);
    assign col_ok      = (in_col >= COL_FIRST) && (col_ph == '0);
    assign emit        = accept && row_ok && col_ok;
    assign last_hs     = rf_valid_q && bus.rf_ready &&
                         (rf_row_q == OROW_LAST) && (rf_col_q == OCOL_LAST);

    assign bus.pixel_ready = pixel_ready;
    assign bus.rf_valid    = rf_valid_q;
    assign bus.rf_data     = rf_data_q;
    assign bus.rf_row      = rf_row_q;
    assign bus.rf_col      = rf_col_q;
    assign bus.frame_done  = (state == S_DONE);

    // Column entering the window: stored lines on top, incoming pixel at the bottom.
    always_comb begin
        for (int r = 0; r < Size-1; r++) col_new[r] = lb[r][in_col];
        col_new[Size-1] = bus.pixel_data;
    end

    // Window after shifting one column left and inserting the new column on the right.
    always_comb begin
        for (int r = 0; r < Size; r++) begin
            for (int c = 0; c < Size-1; c++) win_nx[r][c] = win[r][c+1];
            win_nx[r][Size-1] = col_new[r];
        end
    end

    // Flatten the shifted window into the (ch, r, c) output ordering.
    always_comb begin
        rf_data_nx = '0;
        for (int ch = 0; ch < Depth; ch++)
            for (int r = 0; r < Size; r++)
                for (int c = 0; c < Size; c++)
                    rf_data_nx[(ch*Size*Size + r*Size + c)*DATA_WIDTH +: DATA_WIDTH] =
                        win_nx[r][c][ch*DATA_WIDTH +: DATA_WIDTH];
    end

    // Line buffers and window shift on each accepted pixel; contents need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < Size-2; k++) lb[k][in_col] <= lb[k+1][in_col];
            lb[Size-2][in_col] <= bus.pixel_data;
            for (int r = 0; r < Size; r++)
                for (int c = 0; c < Size; c++)
                    win[r][c] <= win_nx[r][c];
        end
    end

    // Frame sequencing and the output window register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            rf_valid_q <= 1'b0;
            rf_data_q  <= '0;
            rf_row_q   <= '0;
            rf_col_q   <= '0;
        end else begin
            case (state)
                S_IDLE:   if (bus.start) state <= S_STREAM;
                S_STREAM: if (last_hs) state <= S_DONE;
                S_DONE:   state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
            // A qualifying pixel may reload the register in the same edge as a handshake.
            if (emit) begin
                rf_valid_q <= 1'b1;
                rf_data_q  <= rf_data_nx;
                rf_row_q   <= out_row;
                rf_col_q   <= out_col;
            end else if (rf_valid_q && bus.rf_ready) begin
                rf_valid_q <= 1'b0;
            end
        end
    end

    // Raster position, stride phases and output-map coordinates.
    always_ff @(posedge clk) begin
        if (reset || go) begin
            in_row   <= '0;
            in_col   <= '0;
            in_count <= '0;
            row_ph   <= '0;
            col_ph   <= '0;
            out_row  <= '0;
            out_col  <= '0;
        end else if (accept) begin
            in_count <= in_count + NW'(1);
            if (in_col == COL_LAST) begin
                in_col  <= '0;
                col_ph  <= '0;
                out_col <= '0;
                in_row  <= in_row + RW'(1);
                if (in_row >= ROW_FIRST)
                    row_ph <= (row_ph == PH_LAST) ? '0 : row_ph + PHW'(1);
                if (row_ok) out_row <= out_row + 6'd1;
            end else begin
                in_col <= in_col + CW'(1);
                if (in_col >= COL_FIRST)
                    col_ph <= (col_ph == PH_LAST) ? '0 : col_ph + PHW'(1);
                if (col_ok) out_col <= out_col + 6'd1;
            end
        end
    end
endmodule

// File: tb/tb_rf_window_streamer.sv
// Bench for rf_window_streamer: default, stride-2 and two-channel instances, 32x32 frames
// whose pixel value is its raster index.
module tb_rf_window_streamer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rf_window_streamer_if             bus_a();
    rf_window_streamer_if             bus_b();
    rf_window_streamer_if #(.Depth(2)) bus_c();

    rf_window_streamer                u_a (.clk(clk), .reset(reset), .bus(bus_a));
    rf_window_streamer #(.Stride(2))  u_b (.clk(clk), .reset(reset), .bus(bus_b));
    rf_window_streamer #(.Depth(2))   u_c (.clk(clk), .reset(reset), .bus(bus_c));

    logic [799:0] cap_a [784];
    logic [799:0] cap_b [196];
    logic [799:0] cap_c [784];

    typedef struct {
        int          inst;   // 0 = default, 1 = stride 2, 2 = depth 2
        int          row;
        int          col;
        int          elem;
        logic [15:0] exp;
    } spot_t;
    spot_t spots [10];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Expected window k of a frame from raster indices; returns 1 on any difference.
    function automatic int win_bad(input logic [799:0] d, input int depth, input int k,
                                   input int ow, input int st,
                                   input logic [5:0] row, input logic [5:0] col);
        int er, ec, b;
        logic [15:0] e;
        er = k / ow;
        ec = k % ow;
        b  = 0;
        if (row != 6'(er) || col != 6'(ec)) b = 1;
        for (int ch = 0; ch < depth; ch++)
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++) begin
                    e = 16'((er*st + r)*32 + ec*st + c + ch*4096);
                    if (d[(ch*25 + r*5 + c)*16 +: 16] != e) b = 1;
                end
        return b;
    endfunction

    // One frame on the default instance with optional gaps, back-pressure, stall and abort.
    task automatic run_a(input int gap, input int bp, input int stall_at, input int abort_at,
                         input string tag);
        int idx, nwin, bad, nfd, hs_cyc, fd_cyc, stall_left, stall_bad;
        bit stalled, acc, hs;
        logic [799:0] held;
        idx = 0; nwin = 0; bad = 0; nfd = 0; hs_cyc = -10; fd_cyc = -1;
        stall_left = 0; stall_bad = 0; stalled = 0; held = '0;
        bus_a.start = 1'b1;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        for (int cyc = 0; cyc < 30000; cyc++) begin
            bus_a.pixel_valid = (idx < 1024) && ($urandom_range(99) >= gap);
            bus_a.pixel_data  = 16'(idx);
            if (stall_at >= 0 && !stalled && bus_a.rf_valid && nwin == stall_at) begin
                stalled = 1; stall_left = 10; held = 800'(bus_a.rf_data);
            end
            bus_a.rf_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(99) >= bp);
            @(negedge clk);
            if (stall_left > 0) begin
                if (800'(bus_a.rf_data) != held || bus_a.pixel_ready || !bus_a.rf_valid)
                    stall_bad++;
                stall_left--;
            end
            acc = bus_a.pixel_valid && bus_a.pixel_ready;
            hs  = bus_a.rf_valid && bus_a.rf_ready;
            if (hs) begin
                if (nwin < 784) cap_a[nwin] = 800'(bus_a.rf_data);
                bad += win_bad(800'(bus_a.rf_data), 1, nwin, 28, 1, bus_a.rf_row, bus_a.rf_col);
                nwin++;
                hs_cyc = cyc;
            end
            if (bus_a.frame_done) begin nfd++; fd_cyc = cyc; end
            @(posedge clk); #1;
            if (acc) idx++;
            if (abort_at > 0 && idx >= abort_at) break;
            if (nfd > 0 && cyc >= fd_cyc + 3) break;
        end
        bus_a.pixel_valid = 1'b0;
        chk({tag, "_seq_bad"}, bad, 0);
        if (abort_at == 0) begin
            chk({tag, "_nwin"}, nwin, 784);
            chk({tag, "_done_count"}, nfd, 1);
            chk({tag, "_done_timing"}, fd_cyc, hs_cyc + 1);
        end
        if (stall_at >= 0) begin
            chk({tag, "_stall_seen"}, stalled, 1);
            chk({tag, "_stall_hold"}, stall_bad, 0);
        end
    endtask

    // Stride-2 and two-channel frames streamed side by side; start re-pulsed on the latter.
    task automatic run_bc();
        int ib, ic, nb, nc, badb, badc, fdb, fdc, nfb, nfc, hb, hc;
        bit ab, ac;
        ib = 0; ic = 0; nb = 0; nc = 0; badb = 0; badc = 0;
        fdb = -1; fdc = -1; nfb = 0; nfc = 0; hb = -10; hc = -10;
        bus_b.start = 1'b1; bus_c.start = 1'b1;
        bus_b.rf_ready = 1'b1; bus_c.rf_ready = 1'b1;
        @(posedge clk); #1;
        bus_b.start = 1'b0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            bus_b.pixel_valid = (ib < 1024);
            bus_b.pixel_data  = 16'(ib);
            bus_c.pixel_valid = (ic < 1024);
            bus_c.pixel_data  = {16'(ic + 4096), 16'(ic)};
            bus_c.start       = (cyc == 300);
            @(negedge clk);
            ab = bus_b.pixel_valid && bus_b.pixel_ready;
            ac = bus_c.pixel_valid && bus_c.pixel_ready;
            if (bus_b.rf_valid) begin
                if (nb < 196) cap_b[nb] = 800'(bus_b.rf_data);
                badb += win_bad(800'(bus_b.rf_data), 1, nb, 14, 2, bus_b.rf_row, bus_b.rf_col);
                nb++; hb = cyc;
            end
            if (bus_c.rf_valid) begin
                if (nc < 784) cap_c[nc] = bus_c.rf_data;
                badc += win_bad(bus_c.rf_data, 2, nc, 28, 1, bus_c.rf_row, bus_c.rf_col);
                nc++; hc = cyc;
            end
            if (bus_b.frame_done) begin nfb++; fdb = cyc; end
            if (bus_c.frame_done) begin nfc++; fdc = cyc; end
            @(posedge clk); #1;
            if (ab) ib++;
            if (ac) ic++;
            if (nfb > 0 && nfc > 0 && cyc >= fdb + 3 && cyc >= fdc + 3) break;
        end
        bus_b.pixel_valid = 1'b0; bus_c.pixel_valid = 1'b0; bus_c.start = 1'b0;
        chk("s2_nwin", nb, 196);
        chk("s2_seq_bad", badb, 0);
        chk("s2_done_timing", fdb, hb + 1);
        chk("d2_nwin", nc, 784);
        chk("d2_seq_bad", badc, 0);
        chk("d2_done_count", nfc, 1);
    endtask

    initial begin
        spots = '{
            '{0,  0,  0,  0, 16'h0000}, '{0,  0,  0, 24, 16'h0084},
            '{0,  9,  6,  0, 16'h0126}, '{0,  9,  6, 24, 16'h01AA},
            '{0, 27, 27, 24, 16'h03FF}, '{1, 13, 13,  0, 16'h035A},
            '{1, 13, 13, 24, 16'h03DE}, '{2,  0,  0, 25, 16'h1000},
            '{2,  0,  0, 49, 16'h1084}, '{2,  0,  0,  0, 16'h0000}
        };
        bus_a.start = 0; bus_a.pixel_valid = 1; bus_a.pixel_data = 0; bus_a.rf_ready = 1;
        bus_b.start = 0; bus_b.pixel_valid = 1; bus_b.pixel_data = 0; bus_b.rf_ready = 1;
        bus_c.start = 0; bus_c.pixel_valid = 1; bus_c.pixel_data = 0; bus_c.rf_ready = 1;

        // Reset state, with pixels already offered while idle.
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_rf_valid",    bus_a.rf_valid, 0);
        chk("rst_pixel_ready", bus_a.pixel_ready, 0);
        chk("rst_rf_data_nz",  (bus_a.rf_data != '0), 0);
        chk("rst_rf_row",      bus_a.rf_row, 0);
        chk("rst_rf_col",      bus_a.rf_col, 0);
        chk("rst_frame_done",  bus_a.frame_done, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_no_accept_a", bus_a.pixel_ready, 0);
        chk("idle_no_accept_c", bus_c.pixel_ready, 0);
        bus_a.pixel_valid = 0; bus_b.pixel_valid = 0; bus_c.pixel_valid = 0;

        run_a(0, 0, -1, 0, "t1");
        run_a(0, 0, 100, 0, "t3");
        run_a(50, 50, -1, 0, "t4");

        // Reset after 500 accepted pixels, then a clean frame.
        run_a(0, 30, -1, 500, "t5a");
        bus_a.pixel_valid = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t5_rst_rf_valid",    bus_a.rf_valid, 0);
        chk("t5_rst_pixel_ready", bus_a.pixel_ready, 0);
        chk("t5_rst_frame_done",  bus_a.frame_done, 0);
        reset = 1'b0;
        bus_a.pixel_valid = 1'b0;
        @(posedge clk); #1;
        run_a(0, 0, -1, 0, "t5b");

        run_bc();

        // Spot elements from the captured windows.
        for (int i = 0; i < 10; i++) begin
            logic [799:0] d;
            int k;
            if (spots[i].inst == 1) begin k = spots[i].row*14 + spots[i].col; d = cap_b[k]; end
            else if (spots[i].inst == 2) begin k = spots[i].row*28 + spots[i].col; d = cap_c[k]; end
            else begin k = spots[i].row*28 + spots[i].col; d = cap_a[k]; end
            chk($sformatf("spot%0d_i%0d_r%0d_c%0d_e%0d", i, spots[i].inst, spots[i].row,
                          spots[i].col, spots[i].elem),
                d[spots[i].elem*16 +: 16], spots[i].exp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
